// File: rtl/adc_acq_if.sv
// Control and status bundle between the acquisition sequencer and its
// register block / frame timing / DMA neighbours.
interface adc_acq_if #(
  parameter int CNT_W = 32
);
  logic             frame_strobe;
  logic             arm;
  logic             abort;
  logic             soft_trig;
  logic             trig_sel;
  logic             ext_trig;
  logic [CNT_W-1:0] cfg_nsamples;
  logic             dma_ready;

  logic             conv_en;
  logic             sample_req;
  logic [CNT_W-1:0] sample_cnt;
  logic             acq_active;
  logic             acq_done;
  logic             overrun;
  logic [2:0]       state_o;

  modport master (
    output frame_strobe, arm, abort, soft_trig, trig_sel, ext_trig,
           cfg_nsamples, dma_ready,
    input  conv_en, sample_req, sample_cnt, acq_active, acq_done,
           overrun, state_o
  );

  modport slave (
    input  frame_strobe, arm, abort, soft_trig, trig_sel, ext_trig,
           cfg_nsamples, dma_ready,
    output conv_en, sample_req, sample_cnt, acq_active, acq_done,
           overrun, state_o
  );
endinterface

// File: rtl/adc_acq_sequencer.sv
// ADC acquisition sequencer: arm, trigger, gate conversions for N frames and
// issue one sample_req per frame CONV_LAT cycles after its frame strobe.
//
//  state      | meaning
//  IDLE  (0)  | stopped, waiting for arm
//  ARMED (1)  | waiting for soft or external trigger
//  WAIT_FRAME | triggered, waiting for first frame strobe
//  ACQ   (3)  | converting, counting frames
//  DRAIN (4)  | last frame started, waiting for its sample_req
//  DONE  (5)  | acquisition complete
module adc_acq_sequencer #(
  parameter int CNT_W       = 32,
  parameter int CONV_LAT    = 12,
  parameter int SYNC_STAGES = 2
) (
  input logic        clk_100,
  input logic        rst_n,
  adc_acq_if.slave   acq
);
  localparam int LAT_W = $clog2(CONV_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ARMED      = 3'd1,
    S_WAIT_FRAME = 3'd2,
    S_ACQ        = 3'd3,
    S_DRAIN      = 3'd4,
    S_DONE       = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ext_prev_q;
  logic                   ext_rise;
  logic                   trig;
  logic [CNT_W-1:0]       nsamples_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_inc;
  logic [LAT_W-1:0]       lat_q;
  logic                   lat_tc;
  logic                   overrun_q;
  logic                   arm_ok;

  // Edge detect runs in every state so a level held high across arm is not a trigger.
  assign ext_rise = sync_q[SYNC_STAGES-1] & ~ext_prev_q;
  assign trig     = acq.trig_sel ? ext_rise : acq.soft_trig;
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign lat_tc   = (lat_q == LAT_W'(1));
  assign arm_ok   = acq.arm && (state_q == S_IDLE || state_q == S_DONE);

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (acq.abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (acq.arm) state_d = S_ARMED;
        S_ARMED:        if (trig) state_d = S_WAIT_FRAME;
        S_WAIT_FRAME:   if (acq.frame_strobe)
                          state_d = (nsamples_q == CNT_W'(1)) ? S_DRAIN : S_ACQ;
        S_ACQ:          if (acq.frame_strobe && nsamples_q != '0 && cnt_inc == nsamples_q)
                          state_d = S_DRAIN;
        S_DRAIN:        if (lat_tc) state_d = S_DONE;
        default:        state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      ext_prev_q <= 1'b0;
      nsamples_q <= '0;
      cnt_q      <= '0;
      lat_q      <= '0;
      overrun_q  <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], acq.ext_trig};
      ext_prev_q <= sync_q[SYNC_STAGES-1];
      if (acq.abort) begin
        // sample_cnt is kept for readout; only the pending sample_req is cancelled
        lat_q <= '0;
      end else begin
        if (arm_ok) begin
          cnt_q     <= '0;
          overrun_q <= 1'b0;
        end
        if (state_q == S_ARMED && trig) nsamples_q <= acq.cfg_nsamples;
        if (state_q == S_WAIT_FRAME && acq.frame_strobe) begin
          cnt_q <= CNT_W'(1);
          lat_q <= LAT_W'(CONV_LAT);
        end else if (state_q == S_ACQ && acq.frame_strobe) begin
          cnt_q <= cnt_inc;
          lat_q <= LAT_W'(CONV_LAT);
        end else if (lat_q != '0) begin
          lat_q <= lat_q - LAT_W'(1);
        end
        if (lat_tc && !acq.dma_ready) overrun_q <= 1'b1;
      end
    end
  end

  always_comb begin
    acq.conv_en    = (state_q == S_ACQ);
    acq.sample_req = lat_tc;
    acq.sample_cnt = cnt_q;
    acq.acq_active = (state_q == S_WAIT_FRAME) || (state_q == S_ACQ) || (state_q == S_DRAIN);
    acq.acq_done   = (state_q == S_DONE);
    acq.overrun    = overrun_q;
    acq.state_o    = state_q;
  end
endmodule

// File: tb/tb_adc_acq_sequencer.sv
// Self-checking bench for adc_acq_sequencer: scoreboard of expected
// sample_req cycles/counts plus direct status checks.
module tb_adc_acq_sequencer;
  localparam int CNT_W    = 4;
  localparam int CONV_LAT = 12;

  logic clk_100 = 1'b0;
  logic rst_n   = 1'b0;
  int   cyc     = 0;
  int   n_cmp   = 0;
  int   n_err   = 0;

  typedef struct {
    int         cyc;
    logic [3:0] cnt;
  } exp_t;
  exp_t       sb_q[$];
  logic [3:0] exp_cnt;

  adc_acq_if #(.CNT_W(CNT_W)) acq ();

  adc_acq_sequencer #(
    .CNT_W(CNT_W), .CONV_LAT(CONV_LAT), .SYNC_STAGES(2)
  ) dut (
    .clk_100 (clk_100),
    .rst_n   (rst_n),
    .acq     (acq)
  );

  always #5 clk_100 = ~clk_100;
  always @(posedge clk_100) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard: every sample_req must match the oldest expected entry.
  always @(negedge clk_100) begin
    if (rst_n && acq.sample_req) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_sample_req", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sample_req_cycle", cyc, e.cyc);
        chk("sample_req_cnt", acq.sample_cnt, e.cnt);
      end
    end
  end

  task automatic step();
    @(posedge clk_100);
    #2;
  endtask

  task automatic wait_n(input int n);
    repeat (n) step();
  endtask

  task automatic do_arm();
    acq.arm = 1'b1;
    exp_cnt = '0;
    step();
    acq.arm = 1'b0;
  endtask

  task automatic do_soft_trig();
    acq.soft_trig = 1'b1;
    step();
    acq.soft_trig = 1'b0;
  endtask

  task automatic do_abort();
    acq.abort = 1'b1;
    step();
    acq.abort = 1'b0;
  endtask

  task automatic strobe(input bit expect_req);
    exp_t e;
    acq.frame_strobe = 1'b1;
    if (expect_req) begin
      exp_cnt = exp_cnt + 4'd1;
      e.cyc   = cyc + CONV_LAT;
      e.cnt   = exp_cnt;
      sb_q.push_back(e);
    end
    step();
    acq.frame_strobe = 1'b0;
  endtask

  task automatic run_frame(input bit expect_req);
    strobe(expect_req);
    wait_n(49);
  endtask

  initial begin
    acq.frame_strobe = 1'b0;
    acq.arm          = 1'b0;
    acq.abort        = 1'b0;
    acq.soft_trig    = 1'b0;
    acq.trig_sel     = 1'b0;
    acq.ext_trig     = 1'b0;
    acq.cfg_nsamples = 4'd4;
    acq.dma_ready    = 1'b1;
    exp_cnt          = '0;

    wait_n(3);
    chk("rst_state", acq.state_o, 0);
    chk("rst_conv_en", acq.conv_en, 0);
    chk("rst_sample_req", acq.sample_req, 0);
    chk("rst_sample_cnt", acq.sample_cnt, 0);
    chk("rst_overrun", acq.overrun, 0);
    chk("rst_acq_done", acq.acq_done, 0);
    rst_n = 1'b1;
    wait_n(2);

    // Basic 4-frame acquisition with soft trigger
    do_arm();
    chk("t1_armed", acq.state_o, 1);
    do_soft_trig();
    chk("t1_wait_frame", acq.state_o, 2);
    chk("t1_active", acq.acq_active, 1);
    strobe(1'b1);
    chk("t1_acq", acq.state_o, 3);
    chk("t1_conv_en", acq.conv_en, 1);
    chk("t1_cnt1", acq.sample_cnt, 1);
    wait_n(49);
    run_frame(1'b1);
    run_frame(1'b1);
    strobe(1'b1);
    chk("t1_drain", acq.state_o, 4);
    chk("t1_drain_conv_en", acq.conv_en, 0);
    wait_n(49);
    chk("t1_done", acq.state_o, 5);
    chk("t1_acq_done", acq.acq_done, 1);
    chk("t1_cnt4", acq.sample_cnt, 4);
    chk("t1_overrun", acq.overrun, 0);
    chk("t1_sb_empty", sb_q.size(), 0);

    // External trigger: level already high at arm must not trigger
    acq.trig_sel = 1'b1;
    acq.ext_trig = 1'b1;
    wait_n(5);
    do_arm();
    wait_n(10);
    chk("t2_stay_armed", acq.state_o, 1);
    acq.ext_trig = 1'b0;
    wait_n(5);
    acq.ext_trig = 1'b1;
    wait_n(2);
    chk("t2_sync_armed", acq.state_o, 1);
    step();
    chk("t2_wait_frame", acq.state_o, 2);
    do_abort();
    chk("t2_abort_idle", acq.state_o, 0);
    acq.ext_trig = 1'b0;
    acq.trig_sel = 1'b0;
    wait_n(3);

    // Trigger and strobe in the same cycle: that strobe is not counted
    acq.cfg_nsamples = 4'd2;
    do_arm();
    acq.soft_trig    = 1'b1;
    acq.frame_strobe = 1'b1;
    step();
    acq.soft_trig    = 1'b0;
    acq.frame_strobe = 1'b0;
    chk("t3_wait_frame", acq.state_o, 2);
    wait_n(49);
    chk("t3_cnt0", acq.sample_cnt, 0);
    strobe(1'b1);
    chk("t3_cnt1", acq.sample_cnt, 1);
    wait_n(49);
    run_frame(1'b1);
    chk("t3_done", acq.state_o, 5);
    chk("t3_cnt2", acq.sample_cnt, 2);

    // Continuous mode with sample_cnt wrap, then abort
    acq.cfg_nsamples = 4'd0;
    do_arm();
    do_soft_trig();
    acq.cfg_nsamples = 4'd3;
    for (int i = 0; i < 16; i++) run_frame(1'b1);
    chk("t4_wrap0", acq.sample_cnt, 0);
    for (int i = 0; i < 4; i++) run_frame(1'b1);
    chk("t4_cnt_wrap", acq.sample_cnt, 4);
    chk("t4_still_acq", acq.state_o, 3);
    do_abort();
    chk("t4_abort_idle", acq.state_o, 0);
    chk("t4_abort_conv_en", acq.conv_en, 0);
    run_frame(1'b0);
    run_frame(1'b0);
    chk("t4_idle_after", acq.state_o, 0);

    // Overrun on frame 2 of 3, sticky through DONE, cleared by arm
    acq.cfg_nsamples = 4'd3;
    do_arm();
    chk("t5_arm_overrun", acq.overrun, 0);
    do_soft_trig();
    run_frame(1'b1);
    acq.dma_ready = 1'b0;
    run_frame(1'b1);
    acq.dma_ready = 1'b1;
    chk("t5_overrun_set", acq.overrun, 1);
    run_frame(1'b1);
    chk("t5_done", acq.state_o, 5);
    chk("t5_overrun_done", acq.overrun, 1);
    do_arm();
    chk("t5_overrun_clr", acq.overrun, 0);
    chk("t5_rearmed", acq.state_o, 1);
    do_abort();

    // Abort 5 cycles after a strobe cancels that frame's sample_req
    acq.cfg_nsamples = 4'd4;
    do_arm();
    do_soft_trig();
    run_frame(1'b1);
    strobe(1'b0);
    wait_n(4);
    do_abort();
    chk("t6_abort_state", acq.state_o, 0);
    chk("t6_abort_conv_en", acq.conv_en, 0);
    wait_n(60);
    chk("t6_cnt_held", acq.sample_cnt, 2);
    chk("t6_sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
